// File: rtl/mips_muldiv_unit.sv
// ---------------------------------------------------------------------------
// mips_muldiv_unit
//
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// MULT/MULTU use a shift-add multiplier and DIV/DIVU use a restoring divider.
// Both run on operand magnitudes, one bit per enabled clock. A FIXUP cycle
// then applies the sign correction and writes HI/LO. MTHI/MTLO write HI/LO
// directly in a single edge without raising busy.
//
// Optional build macro:
//   MULDIV_FAST_MULT_EN - when defined, MULT/MULTU form the 64-bit product
//                         combinationally from the latched operands and go
//                         straight to FIXUP, so the result lands one edge
//                         after accept. Divide timing is unaffected.
//
// Ports:
//   clk         in   1  rising-edge clock
//   reset       in   1  synchronous, active-high; clears FSM, counter, HI, LO
//   clk_enable  in   1  low = every register holds
//   start       in   1  request strobe, sampled only while busy is low
//   op          in   3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO,
//                       6/7 no-op
//   rs_content  in  32  multiplicand / dividend / MTHI-MTLO source
//   rt_content  in  32  multiplier / divisor
//   busy        out  1  operation in flight (FSM not idle)
//   done        out  1  one-cycle pulse while HI/LO first show a new result
//   hi          out 32  HI register
//   lo          out 32  LO register
//   state_dbg   out  2  current FSM state (0 IDLE, 1 CALC, 2 FIXUP)
//
// Handshake: a request is taken on a rising edge where start=1, busy=0 and
// clk_enable=1. There is no queueing; start is ignored while busy=1.
// ---------------------------------------------------------------------------
module mips_muldiv_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_content,
    input  logic [31:0] rt_content,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  state_dbg
);

    localparam int            CW       = $clog2(ITER);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // acc: multiply = {partial product, remaining multiplier bits};
    //      divide   = {partial remainder, dividend bits / quotient bits}.
    logic [63:0]   acc_q, acc_d;
    // opa: multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [31:0]   opa_q, opa_d;
    logic          is_div_q, is_div_d;
    logic          div0_q, div0_d;
    logic          neg_q, neg_d;          // product / quotient must be negated
    logic          rem_neg_q, rem_neg_d;  // remainder follows dividend sign
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          done_q, done_d;

    // ------------------------------------------------------------------
    // Operand magnitudes at accept time
    // ------------------------------------------------------------------
    logic        op_signed;
    logic        rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign rs_neg    = op_signed & rs_content[31];
    assign rt_neg    = op_signed & rt_content[31];
    assign rs_mag    = rs_neg ? (~rs_content + 32'd1) : rs_content;
    assign rt_mag    = rt_neg ? (~rt_content + 32'd1) : rt_content;

    // ------------------------------------------------------------------
    // One shift-add multiply step: add multiplicand into the upper half
    // when the current multiplier LSB is set, then shift right by one with
    // the carry coming back in at the top.
    // ------------------------------------------------------------------
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // ------------------------------------------------------------------
    // One restoring divide step: shift the next dividend bit into the
    // remainder, trial-subtract the divisor, keep the difference only when
    // it did not go negative. The remainder always stays below the divisor,
    // so 32 bits hold it after each step.
    // ------------------------------------------------------------------
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic [63:0] div_next;

    assign div_shift = {acc_q[63:32], acc_q[31]};
    assign div_diff  = {1'b0, div_shift} - {2'b0, opa_q};
    assign div_next  = div_diff[33] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                    : {div_diff[31:0],  acc_q[30:0], 1'b1};

    // ------------------------------------------------------------------
    // FIXUP results
    // ------------------------------------------------------------------
    logic [63:0] mul_prod, mul_res;
    logic [31:0] quo_res, rem_res;

`ifdef MULDIV_FAST_MULT_EN
    // CALC is skipped for multiplies, so acc_q[31:0] still holds the
    // multiplier magnitude loaded at accept.
    assign mul_prod = {32'd0, opa_q} * {32'd0, acc_q[31:0]};
`else
    assign mul_prod = acc_q;
`endif

    assign mul_res = neg_q     ? (~mul_prod + 64'd1)     : mul_prod;
    assign quo_res = neg_q     ? (~acc_q[31:0] + 32'd1)  : acc_q[31:0];
    assign rem_res = rem_neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        is_div_d  = is_div_q;
        div0_d    = div0_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            opa_d     = rs_mag;
                            acc_d     = {32'd0, rt_mag};
                            neg_d     = rs_neg ^ rt_neg;
                            rem_neg_d = 1'b0;
                            is_div_d  = 1'b0;
                            div0_d    = 1'b0;
                            cnt_d     = '0;
`ifdef MULDIV_FAST_MULT_EN
                            state_d   = ST_FIXUP;
`else
                            state_d   = ST_CALC;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            opa_d     = rt_mag;
                            neg_d     = rs_neg ^ rt_neg;
                            rem_neg_d = rs_neg;
                            is_div_d  = 1'b1;
                            cnt_d     = '0;
                            if (rt_content == 32'd0) begin
                                // Divide by zero: result is preloaded into
                                // acc and FIXUP passes it through untouched.
                                div0_d  = 1'b1;
                                acc_d   = {rs_content, 32'hFFFF_FFFF};
                                state_d = ST_FIXUP;
                            end else begin
                                div0_d  = 1'b0;
                                acc_d   = {32'd0, rs_mag};
                                state_d = ST_CALC;
                            end
                        end
                        OP_MTHI: hi_d = rs_content;
                        OP_MTLO: lo_d = rs_content;
                        default: ;
                    endcase
                end
            end

            ST_CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FIXUP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_FIXUP: begin
                if (div0_q) begin
                    hi_d = acc_q[63:32];
                    lo_d = acc_q[31:0];
                end else if (is_div_q) begin
                    hi_d = rem_res;
                    lo_d = quo_res;
                end else begin
                    hi_d = mul_res[63:32];
                    lo_d = mul_res[31:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers: reset wins, otherwise update only on enabled edges.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else if (clk_enable) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            is_div_q  <= is_div_d;
            div0_q    <= div0_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign state_dbg = state_q;

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit that owns the architectural HI/LO registers of the Harvard MIPS core.
- Sits directly downstream of the ALU/register-file read stage: it takes rs/rt contents plus a decoded op, and feeds HI/LO to the MFHI/MFLO writeback path.
- Raises `busy` so the core can stall PC/writeback while an iterative operation is in flight.

Parameters:
- `ITER`, 32, number of datapath iterations for MULT/DIV; equals the operand width, fixed at 32.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; overrides every other input.
- `clk_enable`  in  1  when low, all state (FSM, counter, accumulators, HI, LO, done) holds.
- `start`  in  1  request strobe; sampled only when `busy`=0.
- `op`  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op.
- `rs_content`  in  32  multiplicand / dividend / MTHI/MTLO source.
- `rt_content`  in  32  multiplier / divisor.
- `busy`  out  1  high while an operation is in progress; the core stalls on MFHI/MFLO and new mul/div.
- `done`  out  1  one-cycle pulse in the cycle HI/LO first show a new mul/div result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

Behaviour:
- Reset: FSM=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0. Reset mid-operation aborts the operation; no partial result is written.
- Accept condition: `start` & !`busy` & `clk_enable` at a rising edge (edge A). When `busy`=1, `start` is ignored; no queueing.
- MTHI/MTLO: at edge A, `hi` or `lo` takes `rs_content`. FSM stays IDLE, `busy` stays 0, no `done` pulse.
- Op 6/7: ignored.
- States:
  - IDLE -> CALC on accepted MULT/MULTU/DIV/DIVU. `busy`=1 from edge A.
  - CALC: one iteration per enabled edge, counter 0..ITER-1. Move to FIXUP after the iteration with counter=ITER-1.
  - FIXUP: one cycle. Apply the sign correction, write `hi`/`lo`, set `done`=1, return to IDLE, `busy`=0.
  - Result therefore appears at edge A+ITER+1 (A+33). `done` is high for exactly the following cycle.
- Operands are latched at edge A. Later changes on `rs_content`/`rt_content` have no effect on the result.
- MULT/MULTU: shift-add on magnitudes (signed ops use absolute values). 64-bit product, `hi`=[63:32], `lo`=[31:0]. Signed product is negated in FIXUP when the operand signs differ.
- DIV/DIVU: restoring division on magnitudes. `lo`=quotient, `hi`=remainder.
  - Signed: quotient is negated if the signs differ; remainder takes the dividend's sign (truncating toward zero).
  - 0x80000000 / 0xFFFFFFFF (signed) -> `lo`=0x80000000, `hi`=0.
- Divide by zero (rt=0, DIV or DIVU): no iterations; CALC is skipped, IDLE -> FIXUP directly. Result `hi`=`rs_content`, `lo`=0xFFFFFFFF, visible at edge A+1, with `done` high the next cycle.
- `clk_enable` low mid-operation: counter and state freeze. Latency extends by the number of disabled cycles.

Optional Feature:
- Macro: `MULDIV_FAST_MULT_EN`.
- Defined: MULT/MULTU compute the full 64-bit product combinationally from the latched operands and skip CALC (IDLE -> FIXUP). Result appears at edge A+1. DIV timing is unchanged.
- Undefined: the iterative 33-cycle multiply described above.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFF rt=0x00000002 -> `busy` for 33 cycles, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE, single `done` pulse.
- MULTU with the same operands -> `hi`=0x00000001, `lo`=0xFFFFFFFE. Toggle operand inputs mid-op; the result is unchanged.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU rs=100 rt=7 -> `lo`=14, `hi`=2.
- DIVU rs=0x12345678 rt=0 -> `hi`=0x12345678, `lo`=0xFFFFFFFF one edge after accept. Then DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- MTHI 0xDEADBEEF then MTLO 0x0BADF00D on consecutive cycles -> `hi`/`lo` update the same edge, `busy` never rises. `start` asserted while `busy` -> ignored, HI/LO from the first op only.
- MULT in flight, `clk_enable` low for 5 cycles -> result at edge A+38. Separately, reset at iteration 10 -> `hi`=`lo`=0, `busy`=0, no `done`.
